// File: rtl/block_memory_ctrl.sv
// block_memory_ctrl
// Latency-modelled main memory sitting below the cache controller. It serves
// word or whole-block reads and writes through a valid/ready request/response
// handshake, and each access takes a programmable number of cycles.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   req_valid       in   request present
//   req_ready       out  controller idle and able to accept a request
//   req_write       in   1 = write, 0 = read
//   req_block       in   1 = whole block, 0 = single word
//   address         in   word address (low offset bits ignored for block ops)
//   write_data      in   block write data, word k at [k*WORD_LEN +: WORD_LEN]
//   resp_valid      out  response present
//   resp_ready      in   consumer accepts response
//   read_data_block out  block containing the last read address
//   read_data_word  out  word at the last read address
//   busy            out  high whenever the controller is not idle
//
// States:
//   S_IDLE | waiting for a request, req_ready high
//   S_WAIT | access latency countdown; executes when the counter reaches 0
//   S_RESP | response presented until resp_ready handshake
module block_memory_ctrl #(
  parameter int ADDRESS_LEN    = 15,
  parameter int WORD_LEN       = 32,
  parameter int BLOCK_WORDS    = 4,
  parameter int MEM_CAPACITY   = 32768,
  parameter int ACCESS_LATENCY = 4,
  parameter int INIT_BASE      = 1024,
  parameter int INIT_END       = 9216
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic                            req_block,
  input  logic [ADDRESS_LEN-1:0]          address,
  input  logic [WORD_LEN*BLOCK_WORDS-1:0] write_data,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [WORD_LEN*BLOCK_WORDS-1:0] read_data_block,
  output logic [WORD_LEN-1:0]             read_data_word,
  output logic                            busy
);

  localparam int BLK_W = WORD_LEN * BLOCK_WORDS;
  localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [ADDRESS_LEN-1:0] ADDR_MASK = ADDRESS_LEN'(MEM_CAPACITY - 1);
  localparam logic [ADDRESS_LEN-1:0] OFF_MASK  = ADDRESS_LEN'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q;
  logic                    blk_q;
  logic [ADDRESS_LEN-1:0]  addr_q;
  logic [BLK_W-1:0]        wdata_q;
  logic [BLK_W-1:0]        rblk_q;
  logic [WORD_LEN-1:0]     rword_q;

  // Storage array carries no reset. Instead a per-word "written" flag is
  // cleared on reset, and any word never written since reset reads back its
  // power-on pattern. This gives the required reset contents without having
  // to sweep the whole array.
  logic [WORD_LEN-1:0]     mem [MEM_CAPACITY];
  logic [MEM_CAPACITY-1:0] written_q;

  logic                    accept;
  logic                    execute;
  logic [ADDRESS_LEN-1:0]  addr_m;
  logic [ADDRESS_LEN-1:0]  base_m;
  logic [BLK_W-1:0]        rd_blk_c;
  logic [WORD_LEN-1:0]     rd_word_c;

  function automatic logic [WORD_LEN-1:0] init_word(input logic [ADDRESS_LEN-1:0] idx);
    if (int'(idx) >= INIT_BASE && int'(idx) < INIT_END) begin
      return WORD_LEN'(idx);
    end
    return '0;
  endfunction

  function automatic logic [WORD_LEN-1:0] cur_word(input logic [ADDRESS_LEN-1:0] idx);
    return written_q[idx] ? mem[idx] : init_word(idx);
  endfunction

  // Address wraps to the capacity, and block accesses align down.
  assign addr_m = addr_q & ADDR_MASK;
  assign base_m = addr_m & ~OFF_MASK;

  always_comb begin
    rd_word_c = cur_word(addr_m);
    rd_blk_c  = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      rd_blk_c[k*WORD_LEN +: WORD_LEN] = cur_word(base_m | ADDRESS_LEN'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    execute = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          execute = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      blk_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rblk_q    <= '0;
      rword_q   <= '0;
      written_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        blk_q   <= req_block;
        addr_q  <= address;
        wdata_q <= write_data;
      end
      if (execute) begin
        if (!wr_q) begin
          rblk_q  <= rd_blk_c;
          rword_q <= rd_word_c;
        end else if (blk_q) begin
          for (int k = 0; k < BLOCK_WORDS; k++) begin
            written_q[base_m | ADDRESS_LEN'(k)] <= 1'b1;
          end
        end else begin
          written_q[addr_m] <= 1'b1;
        end
      end
    end
  end

  // execute is derived from the asynchronously reset state, so a reset
  // during WAIT drops the pending write before it can reach the array.
  always_ff @(posedge clk) begin
    if (execute && wr_q) begin
      if (blk_q) begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          mem[base_m | ADDRESS_LEN'(k)] <= wdata_q[k*WORD_LEN +: WORD_LEN];
        end
      end else begin
        mem[addr_m] <= wdata_q[WORD_LEN-1:0];
      end
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_RESP);
  assign busy            = (state_q != S_IDLE);
  assign read_data_block = rblk_q;
  assign read_data_word  = rword_q;

endmodule

// File: tb/tb_block_memory_ctrl.sv
module tb_block_memory_ctrl;

  localparam int LAT    = 4;
  localparam int BUDGET = 20;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_block;
  logic [14:0]  address;
  logic [127:0] write_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] read_data_block;
  logic [31:0]  read_data_word;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  block_memory_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_block       (req_block),
    .address         (address),
    .write_data      (write_data),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .read_data_block (read_data_block),
    .read_data_word  (read_data_word),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         blk;
    logic [14:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_blk;
    logic [31:0]  exp_word;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for resp_valid after the accept edge; returns cycles elapsed.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Issue one request, scramble inputs after acceptance, and wait for response.
  task automatic do_access(input string tag, input logic wr, input logic blk,
                           input logic [14:0] a, input logic [127:0] wd, output int lat);
    @(negedge clk);
    req_write  = wr;
    req_block  = blk;
    address    = a;
    write_data = wd;
    req_valid  = 1'b1;
    chk({tag, " ready_idle"}, {127'd0, req_ready}, 128'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_block  = ~blk;
    address    = ~a;
    write_data = ~wd;
    chk({tag, " busy_wait"}, {127'd0, busy}, 128'd1);
    wait_resp(lat);
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, " idle_after_hs"}, {126'd0, req_ready, resp_valid}, 128'd2);
  endtask

  initial begin
    int lat;
    string tag;

    vecs[0]  = '{1'b0, 1'b1, 15'd1026, 128'd0, pack4(1024, 1025, 1026, 1027), 32'd1026};
    vecs[1]  = '{1'b0, 1'b0, 15'd9216, 128'd0, 128'd0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 15'd5,    128'd0, 128'd0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 15'd9215, 128'd0, pack4(9212, 9213, 9214, 9215), 32'd9215};
    vecs[4]  = '{1'b1, 1'b1, 15'h40, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3),
                 pack4(9212, 9213, 9214, 9215), 32'd9215};
    vecs[5]  = '{1'b0, 1'b1, 15'h42, 128'd0, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 32'hA2};
    vecs[6]  = '{1'b1, 1'b0, 15'd1025, pack4(32'hDEAD, 32'h1111, 32'h2222, 32'h3333),
                 pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 32'hA2};
    vecs[7]  = '{1'b0, 1'b1, 15'd1024, 128'd0, pack4(1024, 32'hDEAD, 1026, 1027), 32'd1024};
    vecs[8]  = '{1'b0, 1'b1, 15'd1027, 128'd0, pack4(1024, 32'hDEAD, 1026, 1027), 32'd1027};
    vecs[9]  = '{1'b1, 1'b0, 15'd1027, pack4(32'h55, 32'h66, 32'h77, 32'h88),
                 pack4(1024, 32'hDEAD, 1026, 1027), 32'd1027};
    vecs[10] = '{1'b0, 1'b0, 15'd1027, 128'd0, pack4(1024, 32'hDEAD, 1026, 32'h55), 32'h55};
    vecs[11] = '{1'b0, 1'b0, 15'h43, 128'd0, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 32'hA3};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_block  = 1'b0;
    address    = '0;
    write_data = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctrl", {125'd0, req_ready, resp_valid, busy}, 128'd4);
    chk("reset blk", read_data_block, 128'd0);
    chk("reset word", {96'd0, read_data_word}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      tag = $sformatf("vec%0d", i);
      do_access(tag, vecs[i].wr, vecs[i].blk, vecs[i].addr, vecs[i].wdata, lat);
      chk({tag, " latency"}, 128'(lat), 128'(LAT));
      chk({tag, " blk"}, read_data_block, vecs[i].exp_blk);
      chk({tag, " word"}, {96'd0, read_data_word}, {96'd0, vecs[i].exp_word});
      finish_resp(tag);
    end

    // Back-pressure: response held 5 cycles while a second request waits.
    do_access("stall1", 1'b0, 1'b0, 15'd3000, 128'd0, lat);
    chk("stall1 latency", 128'(lat), 128'(LAT));
    chk("stall1 word", {96'd0, read_data_word}, 128'd3000);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_block = 1'b0;
    address   = 15'd3001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall hold%0d ctrl", i), {126'd0, resp_valid, req_ready}, 128'd2);
      chk($sformatf("stall hold%0d word", i), {96'd0, read_data_word}, 128'd3000);
      chk($sformatf("stall hold%0d blk", i), read_data_block, pack4(3000, 3001, 3002, 3003));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("stall hs idle", {125'd0, req_ready, resp_valid, busy}, 128'd4);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    address   = 15'd0;
    chk("stall2 accepted", {127'd0, busy}, 128'd1);
    wait_resp(lat);
    chk("stall2 latency", 128'(lat), 128'(LAT));
    chk("stall2 word", {96'd0, read_data_word}, 128'd3001);
    finish_resp("stall2");

    // Reset during WAIT of a word write aborts it.
    @(negedge clk);
    req_write  = 1'b1;
    req_block  = 1'b0;
    address    = 15'd2000;
    write_data = 128'h1234;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort in wait", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    #1;
    chk("abort ctrl", {125'd0, req_ready, resp_valid, busy}, 128'd4);
    chk("abort blk", read_data_block, 128'd0);
    chk("abort word", {96'd0, read_data_word}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_access("after_abort", 1'b0, 1'b0, 15'd2000, 128'd0, lat);
    chk("after_abort latency", 128'(lat), 128'(LAT));
    chk("after_abort word", {96'd0, read_data_word}, 128'd2000);
    chk("after_abort blk", read_data_block, pack4(2000, 2001, 2002, 2003));
    finish_resp("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_memory_ctrl.md
Name: block_memory_ctrl

Overview:
- Parametrised, latency-modelled main memory that serves cache-line fills and write-backs through a valid/ready request/response handshake.
- Supports word or whole-block reads and writes.
- Sits below the cache controller and replaces the zero-latency combinational memory model.
- Access time is programmable, so cache miss penalties can be exercised cycle-accurately.

Parameters:
ADDRESS_LEN, 15, word-address width
WORD_LEN, 32, bits per word
BLOCK_WORDS, 4, words per cache block (power of 2, >=2)
MEM_CAPACITY, 32768, words stored (= 2**ADDRESS_LEN)
ACCESS_LATENCY, 4, cycles from request accept to response valid (>=1)
INIT_BASE, 1024, first word initialised to its own index at reset
INIT_END, 9216, first word past the initialised range

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_write  in  1  1=write, 0=read
req_block  in  1  1=whole block, 0=single word
address  in  ADDRESS_LEN  word address; low log2(BLOCK_WORDS) bits ignored when req_block=1
write_data  in  WORD_LEN*BLOCK_WORDS  block write data, word k at bits [k*WORD_LEN +: WORD_LEN]; word writes use bits [WORD_LEN-1:0]
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
read_data_block  out  WORD_LEN*BLOCK_WORDS  block containing address, word k = mem[{blk,k}]
read_data_word  out  WORD_LEN  mem[address]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, req_ready=1, resp_valid=0, busy=0, read_data_block=0, read_data_word=0, latency counter=0.
- Memory contents at reset: mem[i]=i (zero-extended) for INIT_BASE<=i<INIT_END, all other words 0.
- Reset mid-access aborts the access. No write is committed and no response is produced.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE: req_ready=1. When req_valid&&req_ready is sampled at a clock edge:
  - latch req_write, req_block, address and write_data.
  - load counter with ACCESS_LATENCY-1.
  - go to WAIT.
- WAIT: req_ready=0, busy=1. Counter decrements each cycle. When the counter is 0 at a clock edge, the access executes:
  - read: latch outputs from memory.
  - block write: all BLOCK_WORDS words are written.
  - word write: only mem[address] is written.
  - then go to RESP.
- Writes commit exactly on the WAIT->RESP edge. Memory changes at no other time.
- Latency: resp_valid rises exactly ACCESS_LATENCY cycles after the accept edge. ACCESS_LATENCY=1 gives WAIT a single cycle.
- RESP: resp_valid=1. Outputs are held stable until resp_valid&&resp_ready at a clock edge, then go to IDLE.
- Write responses are acknowledgements only. Read data outputs keep their previous values during writes.
- Read outputs hold their last read values in all states. They change only on the execute edge of a read.
- One outstanding request. req_valid while req_ready=0 is ignored and not queued; the requester must hold it until accepted.
- A new request can be accepted in the cycle after the RESP handshake, not in the same cycle. Throughput is one access per ACCESS_LATENCY+2 cycles minimum.
- Address wrap: address is masked to MEM_CAPACITY, so no out-of-range access occurs. A block address is aligned down to a BLOCK_WORDS boundary.
- Read-after-write to the same address in consecutive requests returns the newly written data.
- write_data and address changing after acceptance have no effect.

Test Plan:
- Reset, then block read at address 1026, ACCESS_LATENCY=4 -> resp_valid 4 cycles after accept; read_data_block words 0..3 = 1024, 1025, 1026, 1027; read_data_word = 1026.
- Word read at 9216 and at 5 -> read_data_word = 0 for both, confirming the initialised range boundary; word read at 9215 -> 9215.
- Block write 0xA0..0xA3 at address 0x40, then block read at 0x42 -> block = {0xA3, 0xA2, 0xA1, 0xA0}.
- Word write 0xDEAD at 1025, then block read at 1024 -> {1027, 1026, 0xDEAD, 1024}, neighbours unchanged.
- resp_ready held low for 5 cycles in RESP -> resp_valid stays 1 and data stays stable; a second req_valid during this time is not accepted (req_ready=0) and is served only after the handshake.
- Assert rst in WAIT during a word write of 0x1234 to address 2000 -> outputs return to their reset values immediately; a later read of 2000 returns 2000.
